// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - song reader / note player bundle for voice_scheduler
interface voice_scheduler_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    logic              play;
    logic              beat;
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic              advance;
    logic              note_done;
    logic [2:0]        v_load;
    logic [NOTE_W-1:0] v_note0;
    logic [NOTE_W-1:0] v_note1;
    logic [NOTE_W-1:0] v_note2;
    logic [2:0]        v_active;
    logic              dropped;

    modport master (
        output play, beat, new_note, note, duration, advance,
        input  note_done, v_load, v_note0, v_note1, v_note2, v_active, dropped
    );

    modport slave (
        input  play, beat, new_note, note, duration, advance,
        output note_done, v_load, v_note0, v_note1, v_note2, v_active, dropped
    );
endinterface

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - 3-voice allocator and note pacing FSM (option: VOICE_STEAL_EN)
module voice_scheduler #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic            clk,
    input  logic            reset,
    voice_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GATE, ACK} state_t;

    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [DUR_W-1:0]  gate_cnt;
    logic [DUR_W-1:0]  cnt    [3];
    logic [NOTE_W-1:0] note_r [3];
    logic [2:0]        idle_v;
    logic [2:0]        load_sel;
    logic              drop_c;
    logic              tick;
    logic              accept;
    logic              is_note;
    logic              note_done_c;
    logic [2:0]        v_load_r;
    logic              dropped_r;

    assign tick    = bus.beat & bus.play;
    assign accept  = bus.new_note && (state == IDLE);
    assign is_note = (bus.note != '0) && (bus.duration != '0);

    // A voice about to expire on this edge still has cnt != 0, so it is not free.
    assign idle_v = {cnt[2] == '0, cnt[1] == '0, cnt[0] == '0};

`ifdef VOICE_STEAL_EN
    logic [2:0] steal_sel;

    // Victim is the busy voice closest to finishing; lowest index wins ties.
    always_comb begin
        steal_sel = 3'b100;
        if ((cnt[0] <= cnt[1]) && (cnt[0] <= cnt[2]))
            steal_sel = 3'b001;
        else if (cnt[1] <= cnt[2])
            steal_sel = 3'b010;
    end
`endif

    // Pick the lowest idle voice for an accepted note; fall back when all are busy.
    always_comb begin
        load_sel = 3'b000;
        drop_c   = 1'b0;
        if (accept && is_note) begin
            if (idle_v[0])
                load_sel = 3'b001;
            else if (idle_v[1])
                load_sel = 3'b010;
            else if (idle_v[2])
                load_sel = 3'b100;
            else begin
`ifdef VOICE_STEAL_EN
                load_sel = steal_sel;
`else
                drop_c   = 1'b1;
`endif
            end
        end
    end

    // Per-voice duration counters: a load overrides any coincident beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]    <= '0;
                note_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_sel[i]) begin
                    cnt[i]    <= bus.duration;
                    note_r[i] <= bus.note;
                end else if (tick && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - ONE;
                    if (cnt[i] == ONE)
                        note_r[i] <= '0;
                end
            end
        end
    end

    // One-cycle load and drop pulses, valid the cycle after new_note.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_load_r  <= 3'b000;
            dropped_r <= 1'b0;
        end else begin
            v_load_r  <= load_sel;
            dropped_r <= drop_c;
        end
    end

    // Gate counter tracks how long the song reader must wait on an advancing note.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gate_cnt <= '0;
        else if (accept)
            gate_cnt <= bus.duration;
        else if ((state == GATE) && tick && (gate_cnt != '0))
            gate_cnt <= gate_cnt - ONE;
    end

    // Pacing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Pacing next-state and note_done decode; ACK always completes even when paused.
    always_comb begin
        state_nxt   = state;
        note_done_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.new_note) begin
                    if (bus.advance && (bus.duration != '0))
                        state_nxt = GATE;
                    else
                        state_nxt = ACK;
                end
            end
            GATE: begin
                if (tick && (gate_cnt == ONE))
                    state_nxt = ACK;
            end
            ACK: begin
                note_done_c = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.note_done = note_done_c;
    assign bus.v_load    = v_load_r;
    assign bus.dropped   = dropped_r;
    assign bus.v_active  = ~idle_v;
    assign bus.v_note0   = idle_v[0] ? '0 : note_r[0];
    assign bus.v_note1   = idle_v[1] ? '0 : note_r[1];
    assign bus.v_note2   = idle_v[2] ? '0 : note_r[2];
endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
module tb_voice_scheduler;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    voice_scheduler_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

    voice_scheduler #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input int d, input int a, input int b);
        bus.new_note = 1'b1;
        bus.note     = n[NOTE_W-1:0];
        bus.duration = d[DUR_W-1:0];
        bus.advance  = a[0];
        bus.beat     = b[0];
        cycle();
        bus.new_note = 1'b0;
        bus.beat     = 1'b0;
    endtask

    task automatic beats(input int k);
        repeat (k) begin
            bus.beat = 1'b1;
            cycle();
            bus.beat = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.play     = 1'b1;
        bus.beat     = 1'b0;
        bus.new_note = 1'b0;
        bus.note     = '0;
        bus.duration = '0;
        bus.advance  = 1'b0;
        #12;
        check("rst_active", bus.v_active, 0);
        check("rst_done", bus.note_done, 0);
        check("rst_load", bus.v_load, 0);
        check("rst_drop", bus.dropped, 0);
        check("rst_note0", bus.v_note0, 0);
        reset = 1'b0;

        // single advancing note
        issue(12, 3, 1, 0);
        check("single_load", bus.v_load, 3'b001);
        check("single_note0", bus.v_note0, 12);
        check("single_active", bus.v_active, 3'b001);
        check("single_done_early", bus.note_done, 0);
        beats(2);
        check("single_done_2", bus.note_done, 0);
        beats(1);
        check("single_done", bus.note_done, 1);
        check("single_idle", bus.v_active, 0);
        check("single_note0_clr", bus.v_note0, 0);
        cycle();
        check("single_done_once", bus.note_done, 0);

        // chord
        issue(5, 8, 0, 0);
        check("chord0_load", bus.v_load, 3'b001);
        check("chord0_done", bus.note_done, 1);
        cycle();
        issue(9, 8, 0, 0);
        check("chord1_load", bus.v_load, 3'b010);
        check("chord1_done", bus.note_done, 1);
        cycle();
        issue(14, 2, 1, 0);
        check("chord2_load", bus.v_load, 3'b100);
        check("chord2_active", bus.v_active, 3'b111);
        check("chord2_note2", bus.v_note2, 14);
        check("chord2_wait", bus.note_done, 0);

        // new_note during GATE is ignored
        issue(20, 5, 0, 0);
        check("viol_load", bus.v_load, 0);
        check("viol_drop", bus.dropped, 0);
        check("viol_note1", bus.v_note1, 9);
        beats(2);
        check("chord_gate_done", bus.note_done, 1);
        check("chord_v2_free", bus.v_active, 3'b011);
        cycle();
        issue(30, 3, 0, 0);
        check("refill_load", bus.v_load, 3'b100);
        cycle();

        // overflow
        issue(33, 4, 0, 0);
        check("ovf_active", bus.v_active, 3'b111);
        check("ovf_done", bus.note_done, 1);
`ifdef VOICE_STEAL_EN
        check("ovf_load", bus.v_load, 3'b100);
        check("ovf_drop", bus.dropped, 0);
        check("ovf_note2", bus.v_note2, 33);
`else
        check("ovf_load", bus.v_load, 0);
        check("ovf_drop", bus.dropped, 1);
        check("ovf_note2", bus.v_note2, 30);
`endif
        cycle();
        check("ovf_drop_pulse", bus.dropped, 0);

        // pause during GATE
        do_reset();
        issue(7, 3, 1, 0);
        check("pause_load", bus.v_load, 3'b001);
        beats(1);
        bus.play = 1'b0;
        beats(5);
        check("pause_active", bus.v_active, 3'b001);
        check("pause_done", bus.note_done, 0);
        check("pause_note0", bus.v_note0, 7);
        bus.play = 1'b1;
        beats(1);
        check("resume_1", bus.note_done, 0);
        check("resume_1_act", bus.v_active, 3'b001);
        beats(1);
        check("resume_done", bus.note_done, 1);
        check("resume_idle", bus.v_active, 0);
        cycle();

        // same-edge expiry
        issue(11, 1, 0, 0);
        check("exp_setup", bus.v_load, 3'b001);
        cycle();
        issue(22, 2, 0, 1);
        check("exp_load", bus.v_load, 3'b010);
        check("exp_active", bus.v_active, 3'b010);
        check("exp_note0", bus.v_note0, 0);
        check("exp_note1", bus.v_note1, 22);
        cycle();

        // rests
        issue(0, 3, 0, 0);
        check("rest_load", bus.v_load, 0);
        check("rest_done", bus.note_done, 1);
        check("rest_drop", bus.dropped, 0);
        cycle();
        issue(9, 0, 1, 0);
        check("zdur_done", bus.note_done, 1);
        check("zdur_load", bus.v_load, 0);
        cycle();

        // asynchronous reset mid-GATE
        do_reset();
        issue(5, 6, 0, 0);
        cycle();
        issue(6, 6, 1, 0);
        check("mid_active", bus.v_active, 3'b011);
        #3;
        reset = 1'b1;
        #1;
        check("arst_active", bus.v_active, 0);
        check("arst_note0", bus.v_note0, 0);
        check("arst_note1", bus.v_note1, 0);
        check("arst_done", bus.note_done, 0);
        #1;
        reset = 1'b0;
        issue(8, 2, 0, 0);
        check("post_rst_done", bus.note_done, 1);
        check("post_rst_load", bus.v_load, 3'b001);
        check("post_rst_active", bus.v_active, 3'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
